// File: rtl/decode_stage.sv
// RV32I (+ optional M) decode stage. Each instruction is decoded as it is
// accepted and queued in a DEPTH-entry FIFO; every output comes from the
// registered head entry.
package rv32_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS
    } alu_op_e;

    localparam logic [2:0] BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100,
                           BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111;

    localparam logic [6:0] OPC_LUI      = 7'b0110111, OPC_AUIPC  = 7'b0010111,
                           OPC_JAL      = 7'b1101111, OPC_JALR   = 7'b1100111,
                           OPC_BRANCH   = 7'b1100011, OPC_LOAD   = 7'b0000011,
                           OPC_STORE    = 7'b0100011, OPC_OP_IMM = 7'b0010011,
                           OPC_OP       = 7'b0110011, OPC_MISC_MEM = 7'b0001111,
                           OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic [2:0]  branch_op;
        logic [2:0]  mem_size;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } decoded_instr_t;
endpackage

module decode_stage import rv32_pkg::*; #(
    parameter int DEPTH         = 2,
    parameter int ENABLE_M      = 0,
    parameter int CHECK_ILLEGAL = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           instr_valid_i,
    output logic           instr_ready_o,
    input  logic [31:0]    instr_raw_i,
    input  logic [31:0]    pc_i,
    input  logic           flush_i,
    output logic           dec_valid_o,
    input  logic           dec_ready_i,
    output decoded_instr_t decoded_instr_o,
    output logic [31:0]    pc_o,
    output logic           rs1_used_o,
    output logic           rs2_used_o,
    output logic           is_muldiv_o,
    output logic [2:0]     muldiv_op_o,
    output logic           illegal_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        decoded_instr_t dec;
        logic [31:0]    pc;
        logic           rs1_used;
        logic           rs2_used;
        logic           is_muldiv;
        logic [2:0]     muldiv_op;
        logic           illegal;
    } entry_t;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    decoded_instr_t dec;
    logic        rs1_u, rs2_u, md, bad, ill;
    entry_t      ent;

    assign opc   = instr_raw_i[6:0];
    assign f3    = instr_raw_i[14:12];
    assign f7    = instr_raw_i[31:25];
    assign imm_i = {{20{instr_raw_i[31]}}, instr_raw_i[31:20]};
    assign imm_s = {{20{instr_raw_i[31]}}, instr_raw_i[31:25], instr_raw_i[11:7]};
    assign imm_b = {{20{instr_raw_i[31]}}, instr_raw_i[7], instr_raw_i[30:25],
                    instr_raw_i[11:8], 1'b0};
    assign imm_u = {instr_raw_i[31:12], 12'b0};
    assign imm_j = {{12{instr_raw_i[31]}}, instr_raw_i[19:12], instr_raw_i[20],
                    instr_raw_i[30:21], 1'b0};

    // alt selects SUB/SRA in the funct3 slots that have a funct7[5] variant
    function automatic alu_op_e alu_f3(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec     = '0;
        dec.rd  = instr_raw_i[11:7];
        dec.rs1 = instr_raw_i[19:15];
        dec.rs2 = instr_raw_i[24:20];
        rs1_u   = 1'b0;
        rs2_u   = 1'b0;
        md      = 1'b0;
        bad     = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_PASS;
                dec.imm       = imm_u;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.imm       = imm_u;
            end
            OPC_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.imm       = imm_j;
            end
            OPC_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.imm       = imm_i;
                rs1_u         = 1'b1;
                bad           = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.branch    = 1'b1;
                dec.branch_op = f3;
                dec.imm       = imm_b;
                rs1_u         = 1'b1;
                rs2_u         = 1'b1;
                bad           = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.mem_size  = f3;
                dec.imm       = imm_i;
                rs1_u         = 1'b1;
                bad           = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.mem_size  = f3;
                dec.imm       = imm_s;
                rs1_u         = 1'b1;
                rs2_u         = 1'b1;
                bad           = (f3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.imm       = imm_i;
                dec.alu_op    = alu_f3(f3, (f3 == 3'b101) && (f7 == 7'b0100000));
                rs1_u         = 1'b1;
                if (f3 == 3'b001)      bad = (f7 != 7'b0000000);
                else if (f3 == 3'b101) bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                rs1_u         = 1'b1;
                rs2_u         = 1'b1;
                if (ENABLE_M != 0 && f7 == 7'b0000001)
                    md = 1'b1;
                else if (f7 == 7'b0000000)
                    dec.alu_op = alu_f3(f3, 1'b0);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    dec.alu_op = alu_f3(f3, 1'b1);
                else
                    bad = 1'b1;
            end
            OPC_MISC_MEM: ;
            // SYSTEM, unknown opcodes and any word with bits[1:0] != 11
            default: bad = 1'b1;
        endcase
        ill = (CHECK_ILLEGAL != 0) && bad;
        if (ill) begin
            dec     = '0;
            dec.rd  = instr_raw_i[11:7];
            dec.rs1 = instr_raw_i[19:15];
            dec.rs2 = instr_raw_i[24:20];
            rs1_u   = 1'b0;
            rs2_u   = 1'b0;
            md      = 1'b0;
        end
    end

    assign ent = '{dec: dec, pc: pc_i, rs1_used: rs1_u, rs2_used: rs2_u,
                   is_muldiv: md, muldiv_op: md ? f3 : 3'b000, illegal: ill};

    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign instr_ready_o = (cnt_q < CW'(DEPTH));
    assign dec_valid_o   = (cnt_q != '0);
    assign push          = instr_valid_i && instr_ready_o && !flush_i;
    assign pop           = dec_valid_o && dec_ready_i && !flush_i;

    always_comb begin
        cnt_d  = cnt_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (flush_i) begin
            cnt_d  = '0;
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (push) wptr_d = bump(wptr_q);
            if (pop)  rptr_d = bump(rptr_q);
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (!push && pop) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    // Storage is deliberately left unreset; head fields are don't-care when empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= ent;
    end

    assign head            = mem_q[rptr_q];
    assign decoded_instr_o = head.dec;
    assign pc_o            = head.pc;
    assign rs1_used_o      = head.rs1_used;
    assign rs2_used_o      = head.rs2_used;
    assign is_muldiv_o     = head.is_muldiv;
    assign muldiv_op_o     = head.muldiv_op;
    assign illegal_o       = head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an M-enabled and an M-disabled instance
// share one stimulus stream and are each checked against a reference model.
module tb_decode_stage;
    import rv32_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  bop, msz;
        logic        rw, mr, mw, br, jp, u1, u2, md;
        logic [2:0]  mop;
        logic        ill;
    } exp_t;

    localparam logic [3:0] ALU_TAB [8] = '{4'(ALU_ADD), 4'(ALU_SLL), 4'(ALU_SLT),
        4'(ALU_SLTU), 4'(ALU_XOR), 4'(ALU_SRL), 4'(ALU_OR), 4'(ALU_AND)};
    localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
        7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        instr_valid = 1'b0, flush = 1'b0, dec_ready = 1'b0;
    logic [31:0] instr = '0, pc = '0;
    logic [1:0]  rdy, vld, u1, u2, md, ill;
    decoded_instr_t dec [2];
    logic [31:0] pco [2];
    logic [2:0]  mop [2];

    int total = 0, bad = 0;
    exp_t q_m[$], q_n[$];

    decode_stage #(.DEPTH(2), .ENABLE_M(1), .CHECK_ILLEGAL(1)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(rdy[0]),
        .instr_raw_i(instr), .pc_i(pc), .flush_i(flush), .dec_valid_o(vld[0]),
        .dec_ready_i(dec_ready), .decoded_instr_o(dec[0]), .pc_o(pco[0]),
        .rs1_used_o(u1[0]), .rs2_used_o(u2[0]), .is_muldiv_o(md[0]),
        .muldiv_op_o(mop[0]), .illegal_o(ill[0]));

    decode_stage #(.DEPTH(2), .ENABLE_M(0), .CHECK_ILLEGAL(1)) dut_n (
        .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(rdy[1]),
        .instr_raw_i(instr), .pc_i(pc), .flush_i(flush), .dec_valid_o(vld[1]),
        .dec_ready_i(dec_ready), .decoded_instr_o(dec[1]), .pc_o(pco[1]),
        .rs1_used_o(u1[1]), .rs2_used_o(u2[1]), .is_muldiv_o(md[1]),
        .muldiv_op_o(mop[1]), .illegal_o(ill[1]));

    // Reference: legality first, then the per-opcode RV32I field rules.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] a, input bit en_m);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit ok;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e = '0;
        e.pc = a; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        case (op)
            7'h37, 7'h17, 7'h6F, 7'h0F: ok = 1;
            7'h67: ok = (f3 == 0);
            7'h63: ok = !(f3 inside {3'd2, 3'd3});
            7'h03: ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            7'h23: ok = (f3 <= 3'd2);
            7'h13: ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
            7'h33: ok = (f7 == 0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) || (en_m && f7 == 1);
            default: ok = 0;
        endcase
        if (!ok) begin
            e.ill = 1;
            return e;
        end
        e.rw = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h03};
        e.u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        e.u2 = op inside {7'h33, 7'h23, 7'h63};
        e.mr = (op == 7'h03);
        e.mw = (op == 7'h23);
        e.br = (op == 7'h63);
        e.jp = op inside {7'h6F, 7'h67};
        if (op inside {7'h03, 7'h23}) e.msz = f3;
        if (op == 7'h63) e.bop = f3;
        if (op inside {7'h13, 7'h03, 7'h67}) e.imm = 32'($signed(w) >>> 20);
        if (op == 7'h23) e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        if (op == 7'h63) e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (op inside {7'h37, 7'h17}) e.imm = {w[31:12], 12'h000};
        if (op == 7'h6F) e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        if (op == 7'h37) e.alu = 4'(ALU_PASS);
        if (op == 7'h13) e.alu = (f3 == 5 && f7 == 7'h20) ? 4'(ALU_SRA) : ALU_TAB[f3];
        if (op == 7'h33) begin
            if (f7 == 1) begin
                e.md = 1; e.mop = f3;
            end else if (f7 == 7'h20) e.alu = (f3 == 0) ? 4'(ALU_SUB) : 4'(ALU_SRA);
            else e.alu = ALU_TAB[f3];
        end
        return e;
    endfunction

    function automatic exp_t actual(input int k);
        exp_t a;
        a = '0;
        a.pc = pco[k]; a.rd = dec[k].rd; a.rs1 = dec[k].rs1; a.rs2 = dec[k].rs2;
        a.imm = dec[k].imm; a.alu = dec[k].alu_op; a.bop = dec[k].branch_op;
        a.msz = dec[k].mem_size; a.rw = dec[k].reg_write; a.mr = dec[k].mem_read;
        a.mw = dec[k].mem_write; a.br = dec[k].branch; a.jp = dec[k].jump;
        a.u1 = u1[k]; a.u2 = u2[k]; a.md = md[k]; a.mop = mop[k]; a.ill = ill[k];
        return a;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        w = $urandom;
        if ($urandom % 8 != 0) begin
            w[6:0] = OPS[$urandom % 11];
            if (w[6:0] == 7'h33 || w[6:0] == 7'h13)
                case ($urandom % 4)
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic pop_cmp(input int k);
        exp_t a, e;
        bit empty;
        a = actual(k);
        empty = (k == 0) ? (q_m.size() == 0) : (q_n.size() == 0);
        total++;
        if (empty) begin
            bad++;
            $display("FAIL sb%0d unexpected entry got=%h expected=none", k, a);
        end else begin
            if (k == 0) e = q_m.pop_front();
            else        e = q_n.pop_front();
            if (a !== e) begin
                bad++;
                $display("FAIL sb%0d pc=%h got=%h expected=%h", k, e.pc, a, e);
            end
        end
    endtask

    // Stimulus side: expected entries queued when the DUT will accept a push.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q_m.delete();
            q_n.delete();
        end else if (instr_valid && rdy[0]) begin
            q_m.push_back(model(instr, pc, 1'b1));
            q_n.push_back(model(instr, pc, 1'b0));
        end
    end

    // Monitor side: compare each entry the DUT hands to execute.
    always @(negedge clk) begin
        if (rst_n && !flush && dec_ready) begin
            if (vld[0]) pop_cmp(0);
            if (vld[1]) pop_cmp(1);
        end
    end

    task automatic push_one(input logic [31:0] w, input logic [31:0] a);
        instr = w; pc = a; instr_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy[0]) break;
            if (i == 49) chk("push_timeout", 32'(rdy[0]), 32'd1);
        end
        @(posedge clk); #1 instr_valid = 1'b0;
    endtask

    task automatic pop_head();
        @(posedge clk); #1 dec_ready = 1'b1;
        @(posedge clk); #1 dec_ready = 1'b0;
    endtask

    task automatic drain();
        instr_valid = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!vld[0] && !vld[1] && q_m.size() == 0 && q_n.size() == 0) break;
        end
        chk("drain_left", 32'(q_m.size() + q_n.size()), 32'd0);
        chk("drain_valid", 32'(vld), 32'd0);
        @(posedge clk); #1 dec_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1);
    end

    initial begin
        #23 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_ready", 32'(rdy), 32'd3);
        @(posedge clk); #1;

        push_one(32'h00500093, 32'h100);
        @(negedge clk);
        chk("addi_valid", 32'(vld[0]), 32'd1);
        chk("addi_rd", 32'(dec[0].rd), 32'd1);
        chk("addi_imm", dec[0].imm, 32'd5);
        chk("addi_alu", 32'(dec[0].alu_op), 32'(ALU_ADD));
        chk("addi_rw", 32'(dec[0].reg_write), 32'd1);
        chk("addi_rs", 32'({u1[0], u2[0]}), 32'b10);
        chk("addi_pc", pco[0], 32'h100);
        pop_head();

        push_one(32'h402081B3, 32'h104);
        @(negedge clk);
        chk("sub_alu", 32'(dec[0].alu_op), 32'(ALU_SUB));
        chk("sub_regs", {17'd0, dec[0].rd, dec[0].rs1, dec[0].rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
        pop_head();

        push_one(32'hFE000EE3, 32'h108);
        @(negedge clk);
        chk("beq_branch", 32'(dec[0].branch), 32'd1);
        chk("beq_imm", dec[0].imm, 32'hFFFFFFFC);
        chk("beq_op", 32'(dec[0].branch_op), 32'(BR_EQ));
        pop_head();

        push_one(32'h027302B3, 32'h10C);
        @(negedge clk);
        chk("mul_m_md", 32'({md[0], mop[0]}), 32'b1000);
        chk("mul_m_rd", 32'(dec[0].rd), 32'd5);
        chk("mul_m_ill", 32'(ill[0]), 32'd0);
        chk("mul_n_ill", 32'(ill[1]), 32'd1);
        chk("mul_n_rw", 32'(dec[1].reg_write), 32'd0);
        pop_head();

        foreach (OPS[i]) if (i < 3) begin
            logic [31:0] bw [3];
            bw = '{32'h00000000, 32'h0000307F, 32'h00109067};
            push_one(bw[i], 32'h200 + 32'(i) * 4);
            @(negedge clk);
            chk("illegal_flag", 32'(ill), 32'd3);
            chk("illegal_rs_used", 32'({u1[0], u2[0], u1[1], u2[1]}), 32'd0);
            pop_head();
        end

        // Backpressure: three offers with execute stalled.
        dec_ready = 1'b0; instr = 32'h00100093; pc = 32'h300; instr_valid = 1'b1;
        @(negedge clk); chk("bp_ready0", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1 instr = 32'h00200113; pc = 32'h304;
        @(negedge clk); chk("bp_ready1", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1 instr = 32'h00300193; pc = 32'h308;
        @(negedge clk); chk("bp_full", 32'(rdy[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_hold_ready", 32'(rdy[0]), 32'd0);
        chk("bp_hold_head", pco[0], 32'h300);
        @(posedge clk); #1 dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy[0]) break;
        end
        @(posedge clk); #1 instr_valid = 1'b0;
        drain();

        // Flush with two entries held and a third offered.
        push_one(32'h00400213, 32'h400);
        push_one(32'h00500293, 32'h404);
        instr = 32'h00600313; pc = 32'h408; instr_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; instr_valid = 1'b0;
        @(negedge clk); chk("flush_valid", 32'(vld), 32'd0);
        @(posedge clk); #1;
        push_one(32'h00700393, 32'h40C);
        drain();

        // Asynchronous reset with the FIFO full and a push on offer.
        push_one(32'h00800413, 32'h500);
        push_one(32'h00900493, 32'h504);
        instr = 32'h00A00513; pc = 32'h508; instr_valid = 1'b1;
        @(posedge clk); #3 rst_n = 1'b0; instr_valid = 1'b0;
        #1 chk("arst_valid", 32'(vld), 32'd0);
        chk("arst_ready", 32'(rdy), 32'd3);
        @(negedge clk); @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk); chk("arst_after", 32'(vld), 32'd0);
        @(posedge clk); #1;

        for (int c = 0; c < 3000; c++) begin
            instr_valid = ($urandom % 3) != 0;
            instr       = gen();
            pc          = $urandom & 32'hFFFFFFFC;
            dec_ready   = ($urandom % 4) != 0;
            flush       = ($urandom % 40) == 0;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
